// File: rtl/riscv_pkg.sv
// riscv_pkg: shared divider op codes, FSM states and latency constant
package riscv_pkg;
  typedef enum logic [1:0] {DIV = 2'b00, DIVU = 2'b01, REM = 2'b10, REMU = 2'b11} div_op_e;
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} div_state_e;
  localparam int DIV_LATENCY = 34;
endpackage

// File: rtl/div_datapath.sv
// div_datapath: restoring radix-2 remainder/quotient shift registers
module div_datapath #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic             i_step,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_quo,
  output logic [WIDTH-1:0] o_rem
);
  logic [WIDTH-1:0] r_quo, r_rem, r_div;
  logic [WIDTH:0]   w_part, w_diff;
  logic             w_ge;
  // one extra bit keeps the compare exact for divisors with the MSB set
  always_comb begin
    w_part = {r_rem, r_quo[WIDTH-1]};
    w_diff = w_part - {1'b0, r_div};
    w_ge   = w_part >= {1'b0, r_div};
  end
  // dividend shifts out of the quotient register as quotient bits shift in
  always_ff @(posedge clk) begin
    if (reset) begin
      r_quo <= '0;
      r_rem <= '0;
      r_div <= '0;
    end else if (i_load) begin
      r_quo <= i_dividend;
      r_rem <= '0;
      r_div <= i_divisor;
    end else if (i_step) begin
      r_rem <= w_ge ? w_diff[WIDTH-1:0] : w_part[WIDTH-1:0];
      r_quo <= {r_quo[WIDTH-2:0], w_ge};
    end
  end
  assign o_quo = r_quo;
  assign o_rem = r_rem;
endmodule

// File: rtl/div_unit.sv
// div_unit: iterative RV32M DIV/DIVU/REM/REMU with start/busy/done handshake; DIV_EARLY_OUT_EN enables single-cycle special cases
module div_unit
  import riscv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             flush,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);
  localparam int CW = $clog2(WIDTH) + 1;
  div_state_e       r_state, w_next;
  div_op_e          r_op;
  logic [CW-1:0]    r_cnt;
  logic             r_qneg, r_rneg, r_bzero;
  logic [WIDTH-1:0] r_result;
  logic             w_accept, w_signed, w_bzero, w_early;
  logic [WIDTH-1:0] w_a_abs, w_b_abs, w_quo, w_rem, w_q, w_r, w_fix, w_early_res;
`ifdef DIV_EARLY_OUT_EN
  logic w_ovf;
  assign w_ovf       = w_signed & (src_a == {1'b1, {(WIDTH-1){1'b0}}}) & (&src_b);
  assign w_early     = w_accept & (w_bzero | w_ovf);
  assign w_early_res = w_bzero ? (op[1] ? src_a : '1) : (op[1] ? '0 : src_a);
`else
  assign w_early     = 1'b0;
  assign w_early_res = '0;
`endif
  // operand preparation on the start edge and sign fix-up after the iterations
  always_comb begin
    w_accept = start & ~flush & (r_state == IDLE | r_state == DONE);
    w_signed = ~op[0];
    w_bzero  = src_b == '0;
    w_a_abs  = (w_signed & src_a[WIDTH-1]) ? -src_a : src_a;
    w_b_abs  = (w_signed & src_b[WIDTH-1]) ? -src_b : src_b;
    w_q      = r_bzero ? '1 : (r_qneg ? -w_quo : w_quo);
    w_r      = r_rneg ? -w_rem : w_rem;
    w_fix    = (r_op == REM | r_op == REMU) ? w_r : w_q;
  end
  // next state: flush dominates, CALC runs WIDTH steps, FIX then DONE
  always_comb begin
    w_next = flush ? IDLE :
             (r_state == CALC) ? ((r_cnt == CW'(WIDTH - 1)) ? FIX : CALC) :
             (r_state == FIX) ? DONE :
             w_accept ? (w_early ? DONE : CALC) : IDLE;
  end
  // state register
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else r_state <= w_next;
  end
  // captured op/signs, iteration counter and result register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_op     <= DIV;
      r_qneg   <= 1'b0;
      r_rneg   <= 1'b0;
      r_bzero  <= 1'b0;
      r_cnt    <= '0;
      r_result <= '0;
    end else begin
      if (w_accept) begin
        r_op    <= div_op_e'(op);
        r_qneg  <= w_signed & (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
        r_rneg  <= w_signed & src_a[WIDTH-1];
        r_bzero <= w_bzero;
      end
      r_cnt <= w_accept ? '0 : (r_state == CALC ? r_cnt + 1'b1 : r_cnt);
      if (r_state == FIX & ~flush) r_result <= w_fix;
      else if (w_early) r_result <= w_early_res;
    end
  end
  div_datapath #(.WIDTH(WIDTH)) u_dp (
    .clk       (clk),
    .reset     (reset),
    .i_load    (w_accept),
    .i_step    (r_state == CALC),
    .i_dividend(w_a_abs),
    .i_divisor (w_b_abs),
    .o_quo     (w_quo),
    .o_rem     (w_rem)
  );
  assign busy   = r_state == CALC | r_state == FIX;
  assign done   = r_state == DONE;
  assign result = r_result;
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed vector table plus handshake/flush/reset sequences for div_unit
module tb_div_unit;
  import riscv_pkg::*;
`ifdef DIV_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif
  logic        clk = 1'b0, reset = 1'b1, start = 1'b0, flush = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] src_a = '0, src_b = '0;
  logic        busy, done;
  logic [31:0] result;
  int checks = 0, errors = 0;
  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    bit          special;
    string       name;
  } vec_t;
  vec_t tbl[16];
  always #5 clk = ~clk;
  div_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .flush(flush), .op(op),
    .src_a(src_a), .src_b(src_b), .busy(busy), .done(done), .result(result)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  function automatic int exp_lat(input bit sp);
    return (EARLY && sp) ? 1 : DIV_LATENCY;
  endfunction
  task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] e, input int lat_e, input int pulse_at,
                       input bit immediate, input string name);
    int lat;
    bit busy_ok;
    if (!immediate) @(negedge clk);
    op = o; src_a = a; src_b = b; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    lat = 0; busy_ok = 1'b1;
    for (int k = 1; k <= 60 && lat == 0; k++) begin
      @(negedge clk);
      if (pulse_at != 0 && k == pulse_at) begin
        start = 1'b1; op = REM; src_a = 32'd9; src_b = 32'd3;
      end else if (pulse_at != 0 && k == pulse_at + 1) start = 1'b0;
      if (done) begin
        lat = k;
        if (busy) busy_ok = 1'b0;
      end else if (busy !== (lat_e > 1)) busy_ok = 1'b0;
    end
    chk({name, " latency"}, lat, lat_e);
    chk({name, " busy"}, {31'd0, busy_ok}, 32'd1);
    chk({name, " result"}, result, e);
  endtask
  initial begin
    logic [31:0] prev;
    bit ok;
    tbl[0]  = '{DIVU, 32'd100, 32'd7, 32'd14, 1'b0, "divu 100/7"};
    tbl[1]  = '{REMU, 32'd100, 32'd7, 32'd2, 1'b0, "remu 100/7"};
    tbl[2]  = '{DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 1'b0, "div -7/2"};
    tbl[3]  = '{REM, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 1'b0, "rem -7/2"};
    tbl[4]  = '{DIV, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0, "div 7/-2"};
    tbl[5]  = '{REM, 32'd7, 32'hFFFFFFFE, 32'd1, 1'b0, "rem 7/-2"};
    tbl[6]  = '{DIVU, 32'd5, 32'd0, 32'hFFFFFFFF, 1'b1, "divu 5/0"};
    tbl[7]  = '{REMU, 32'd5, 32'd0, 32'd5, 1'b1, "remu 5/0"};
    tbl[8]  = '{DIV, 32'd5, 32'd0, 32'hFFFFFFFF, 1'b1, "div 5/0"};
    tbl[9]  = '{REM, 32'd5, 32'd0, 32'd5, 1'b1, "rem 5/0"};
    tbl[10] = '{DIV, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFF, 1'b1, "div -5/0"};
    tbl[11] = '{REM, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, 1'b1, "rem -5/0"};
    tbl[12] = '{DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1, "div ovf"};
    tbl[13] = '{REM, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1'b1, "rem ovf"};
    tbl[14] = '{DIVU, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'd1, 1'b0, "divu max"};
    tbl[15] = '{REMU, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'd1, 1'b0, "remu max"};
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset done", {31'd0, done}, 32'd0);
    chk("reset result", result, 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 16; i++)
      do_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].exp, exp_lat(tbl[i].special), 0, 1'b0, tbl[i].name);
    @(negedge clk);
    chk("done pulse width", {31'd0, done}, 32'd0);
    chk("result hold", result, 32'd1);
    prev = result;
    op = DIVU; src_a = 32'd100; src_b = 32'd7; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int k = 1; k <= 10; k++) @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    ok = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (busy || done) ok = 1'b0;
    end
    chk("flush idle", {31'd0, ok}, 32'd1);
    chk("flush result kept", result, prev);
    do_op(DIVU, 32'd1000, 32'd10, 32'd100, 34, 0, 1'b0, "after flush");
    do_op(DIVU, 32'd100, 32'd7, 32'd14, 34, 5, 1'b0, "start in calc");
    do_op(DIVU, 32'd200, 32'd9, 32'd22, 34, 0, 1'b0, "b2b first");
    do_op(DIVU, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 34, 0, 1'b1, "b2b second");
    @(negedge clk);
    prev = result;
    op = DIVU; src_a = 32'd50; src_b = 32'd5; start = 1'b1; flush = 1'b1;
    @(posedge clk); #1 begin start = 1'b0; flush = 1'b0; end
    ok = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (busy || done) ok = 1'b0;
    end
    chk("start+flush idle", {31'd0, ok}, 32'd1);
    chk("start+flush result", result, prev);
    op = DIVU; src_a = 32'd100; src_b = 32'd7; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int k = 1; k <= 20; k++) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("mid reset busy", {31'd0, busy}, 32'd0);
    chk("mid reset done", {31'd0, done}, 32'd0);
    chk("mid reset result", result, 32'd0);
    reset = 1'b0;
    do_op(DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 34, 0, 1'b0, "after reset");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
